// File: rtl/gdg_pkg.sv
// Shared types and helpers for the multi-channel gate/delay generator.
// Optional missed-trigger counters are enabled by GDG_MISSED_CNT_EN.
package gdg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_PULSE
  } gdg_state_e;

  localparam int GDG_N_CH   = 4;
  localparam int GDG_CNT_W  = 32;
  localparam int GDG_MISS_W = 16;

  function automatic int gdg_lsb(int ch, int w);
    return ch * w;
  endfunction

endpackage

// File: rtl/gdg_if.sv
// Per-channel configuration and status bus of the gate/delay generator.
// Master drives configuration, slave (the generator) drives status.
interface gdg_if #(
  parameter int N_CH   = 4,
  parameter int CNT_W  = 32,
  parameter int MISS_W = 16
);

  logic [N_CH-1:0]        i_ch_en;
  logic [N_CH-1:0]        i_retrig;
  logic [N_CH*CNT_W-1:0]  i_delay;
  logic [N_CH*CNT_W-1:0]  i_width;
  logic [N_CH-1:0]        o_pulse;
  logic [N_CH-1:0]        o_busy;
  logic                   o_any_busy;
  logic [N_CH*MISS_W-1:0] o_missed;

  modport master (
    output i_ch_en,
    output i_retrig,
    output i_delay,
    output i_width,
    input  o_pulse,
    input  o_busy,
    input  o_any_busy,
    input  o_missed
  );

  modport slave (
    input  i_ch_en,
    input  i_retrig,
    input  i_delay,
    input  i_width,
    output o_pulse,
    output o_busy,
    output o_any_busy,
    output o_missed
  );

endinterface

// File: rtl/gdg_channel.sv
// One gate channel: IDLE/DELAY/PULSE FSM with snapshotted width.
// Missed-trigger counter is built only with GDG_MISSED_CNT_EN.
module gdg_channel
  import gdg_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int MISS_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trig_evt,
  input  logic              en,
  input  logic              retrig,
  input  logic [CNT_W-1:0]  delay,
  input  logic [CNT_W-1:0]  width,
  input  logic              clr_missed,
  output logic              pulse,
  output logic              busy,
  output logic [MISS_W-1:0] missed
);

  gdg_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] w_q, w_d;
  logic             pulse_q, pulse_d;
  logic             busy_q, busy_d;
  logic             start;
  logic             last;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    start   = trig_evt & en &
              ((state_q == ST_IDLE) | retrig);
    last    = (cnt_q == CNT_W'(1));
    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (start) begin
      w_d = width;
      unique case (1'b1)
        (delay != '0): begin
          state_d = ST_DELAY;
          cnt_d   = delay;
        end
        (delay == '0 && width != '0): begin
          state_d = ST_PULSE;
          cnt_d   = width;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end else begin
      unique case (state_q)
        ST_DELAY: begin
          if (!last) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (w_q != '0) begin
            state_d = ST_PULSE;
            cnt_d   = w_q;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        ST_PULSE: begin
          if (!last) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    pulse_d = (state_d == ST_PULSE);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      w_q     <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
    end
  end

  assign pulse = pulse_q;
  assign busy  = busy_q;

`ifdef GDG_MISSED_CNT_EN
  logic [MISS_W-1:0] miss_q, miss_d;
  logic              miss_evt;

  // clear beats a coinciding increment
  always_comb begin
    miss_evt = trig_evt & en &
               (state_q != ST_IDLE) & ~retrig;
    miss_d   = miss_q;
    if (clr_missed) begin
      miss_d = '0;
    end else if (miss_evt && (miss_q != '1)) begin
      miss_d = miss_q + MISS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_q <= '0;
    end else begin
      miss_q <= miss_d;
    end
  end

  assign missed = miss_q;
`else
  logic unused_clr;
  assign unused_clr = clr_missed;
  assign missed     = '0;
`endif

endmodule

// File: rtl/multi_gate_delay_gen.sv
// Multi-channel gate/delay generator: shared trigger sync + N_CH channels.
// Missed-trigger counters are enabled by GDG_MISSED_CNT_EN.
module multi_gate_delay_gen
  import gdg_pkg::*;
#(
  parameter int N_CH   = GDG_N_CH,
  parameter int CNT_W  = GDG_CNT_W,
  parameter int MISS_W = GDG_MISS_W
) (
  input  logic  i_clk,
  input  logic  i_rst_n,
  input  logic  i_trigger,
  input  logic  i_clr_missed,
  gdg_if.slave  bus
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic sync3_q, sync3_d;
  logic trig_evt_q, trig_evt_d;

  logic [N_CH-1:0]        pulse_w;
  logic [N_CH-1:0]        busy_w;
  logic [N_CH*MISS_W-1:0] missed_w;

  // sync3 holds the previous synchronised level for edge detect
  always_comb begin
    sync1_d    = i_trigger;
    sync2_d    = sync1_q;
    sync3_d    = sync2_q;
    trig_evt_d = sync2_q & ~sync3_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      trig_evt_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      sync3_q    <= sync3_d;
      trig_evt_q <= trig_evt_d;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    gdg_channel #(
      .CNT_W  (CNT_W),
      .MISS_W (MISS_W)
    ) u_ch (
      .clk        (i_clk),
      .rst_n      (i_rst_n),
      .trig_evt   (trig_evt_q),
      .en         (bus.i_ch_en[c]),
      .retrig     (bus.i_retrig[c]),
      .delay      (bus.i_delay[gdg_lsb(c, CNT_W) +: CNT_W]),
      .width      (bus.i_width[gdg_lsb(c, CNT_W) +: CNT_W]),
      .clr_missed (i_clr_missed),
      .pulse      (pulse_w[c]),
      .busy       (busy_w[c]),
      .missed     (missed_w[gdg_lsb(c, MISS_W) +: MISS_W])
    );
  end

  assign bus.o_pulse    = pulse_w;
  assign bus.o_busy     = busy_w;
  assign bus.o_any_busy = |busy_w;
  assign bus.o_missed   = missed_w;

endmodule

// File: tb/tb_multi_gate_delay_gen.sv
// Event scoreboard bench for multi_gate_delay_gen.
// Honours GDG_MISSED_CNT_EN when computing expected missed counts.
module tb_multi_gate_delay_gen;

  localparam int N  = 4;
  localparam int CW = 32;
  localparam int MW = 16;

  typedef struct {
    int cyc;
    int kind;
    int val;
  } ev_t;

  logic clk;
  logic rst_n;
  logic trig;
  logic clr;
  int   cyc;
  int   total;
  int   bad;
  bit   mon_on;
  int   k;
  int   k2;
  int   t0;

  ev_t  exp_q [0:N][$];
  logic pb [0:N];
  logic pp [0:N-1];
  int   pm [0:N-1];

  gdg_if #(.N_CH(N), .CNT_W(CW), .MISS_W(MW)) bus ();

  multi_gate_delay_gen #(
    .N_CH   (N),
    .CNT_W  (CW),
    .MISS_W (MW)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_trigger    (trig),
    .i_clr_missed (clr),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic exp_push(int ch, int cy, int kd, int v);
    ev_t e;
    int  idx;
    bit  found;
    e.cyc = cy;
    e.kind = kd;
    e.val = v;
    idx = exp_q[ch].size();
    found = 1'b0;
    for (int j = 0; j < exp_q[ch].size(); j++) begin
      if (!found &&
          exp_q[ch][j].cyc * 4 + exp_q[ch][j].kind > cy * 4 + kd) begin
        idx = j;
        found = 1'b1;
      end
    end
    exp_q[ch].insert(idx, e);
  endtask

  task automatic gate(int ch, int t, int d, int w, bit any);
    if (d == 0 && w == 0) return;
    exp_push(ch, t, 0, 1);
    exp_push(ch, t + d + w, 0, 0);
    if (any) begin
      exp_push(N, t, 0, 1);
      exp_push(N, t + d + w, 0, 0);
    end
    if (w > 0) begin
      exp_push(ch, t + d, 1, 1);
      exp_push(ch, t + d + w, 1, 0);
    end
  endtask

  task automatic chk_ev(int ch, int kd, int v);
    ev_t e;
    total++;
    if (exp_q[ch].size() == 0) begin
      bad++;
      $display("FAIL ev ch%0d kind%0d unexpected val=%0d cyc=%0d",
               ch, kd, v, cyc);
    end else begin
      e = exp_q[ch].pop_front();
      if (e.cyc != cyc || e.kind != kd || e.val != v) begin
        bad++;
        $display("FAIL ev ch%0d got kind%0d val=%0d cyc=%0d want kind%0d val=%0d cyc=%0d",
                 ch, kd, v, cyc, e.kind, e.val, e.cyc);
      end
    end
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      for (int c = 0; c <= N; c++) begin
        logic b;
        b = (c == N) ? bus.o_any_busy : bus.o_busy[c];
        if (b !== pb[c]) chk_ev(c, 0, int'(b));
        pb[c] = b;
        if (c < N) begin
          logic p;
          int   m;
          p = bus.o_pulse[c];
          m = int'(bus.o_missed[c*MW +: MW]);
          if (p !== pp[c]) chk_ev(c, 1, int'(p));
          pp[c] = p;
          if (m != pm[c]) chk_ev(c, 2, m);
          pm[c] = m;
        end
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_dw(int ch, int d, int w);
    bus.i_delay[ch*CW +: CW] = d;
    bus.i_width[ch*CW +: CW] = w;
  endtask

  task automatic trig_hi(output int kk);
    trig = 1'b1;
    kk = cyc + 1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    mon_on = 1'b0;
    for (int c = 0; c <= N; c++) pb[c] = 1'b0;
    for (int c = 0; c < N; c++) begin
      pp[c] = 1'b0;
      pm[c] = 0;
    end
    rst_n = 1'b0;
    trig = 1'b0;
    clr = 1'b0;
    bus.i_ch_en = '1;
    bus.i_retrig = '0;
    bus.i_delay = '0;
    bus.i_width = '0;
    tick(3);
    #2 rst_n = 1'b1;
    tick(2);
    chk("rst_pulse", 64'(bus.o_pulse), 64'd0);
    chk("rst_busy", 64'(bus.o_busy), 64'd0);
    chk("rst_any", 64'(bus.o_any_busy), 64'd0);
    chk("rst_missed", bus.o_missed, 64'd0);
    mon_on = 1'b1;

    // basic gate D=5 W=3
    set_dw(0, 5, 3);
    trig_hi(k);
    gate(0, k + 3, 5, 3, 1);
    tick(3); trig = 1'b0; tick(15);
    set_dw(0, 0, 0);

    // D=0 W=4
    set_dw(1, 0, 4);
    trig_hi(k);
    gate(1, k + 3, 0, 4, 1);
    tick(3); trig = 1'b0; tick(10);
    set_dw(1, 0, 0);

    // D=0 W=0: nothing at all
    trig_hi(k);
    tick(3); trig = 1'b0; tick(8);
    chk("zero_missed", bus.o_missed, 64'd0);

    // D=3 W=0: busy only
    set_dw(3, 3, 0);
    trig_hi(k);
    gate(3, k + 3, 3, 0, 1);
    tick(3); trig = 1'b0; tick(10);
    set_dw(3, 0, 0);

    // no-retrigger: second event at T0+6 ignored
    set_dw(0, 10, 10);
    trig_hi(k);
    t0 = k + 3;
    gate(0, t0, 10, 10, 1);
`ifdef GDG_MISSED_CNT_EN
    exp_push(0, t0 + 6, 2, 1);
`endif
    tick(3); trig = 1'b0; tick(3);
    trig_hi(k2);
    tick(3); trig = 1'b0; tick(25);
    clr = 1'b1;
`ifdef GDG_MISSED_CNT_EN
    exp_push(0, cyc + 1, 2, 0);
`endif
    tick(1); clr = 1'b0; tick(2);
    set_dw(0, 0, 0);

    // retrigger mid-pulse, D=2 W=8
    set_dw(1, 2, 8);
    bus.i_retrig[1] = 1'b1;
    trig_hi(k);
    t0 = k + 3;
    exp_push(1, t0, 0, 1);
    exp_push(1, t0 + 2, 1, 1);
    exp_push(1, t0 + 6, 1, 0);
    exp_push(1, t0 + 8, 1, 1);
    exp_push(1, t0 + 16, 0, 0);
    exp_push(1, t0 + 16, 1, 0);
    exp_push(N, t0, 0, 1);
    exp_push(N, t0 + 16, 0, 0);
    tick(3); trig = 1'b0; tick(3);
    trig_hi(k2);
    tick(3); trig = 1'b0; tick(25);
    bus.i_retrig[1] = 1'b0;
    set_dw(1, 0, 0);

    // snapshot on ch2, enable abort on ch3
    set_dw(2, 6, 4);
    set_dw(3, 2, 10);
    trig_hi(k);
    t0 = k + 3;
    gate(2, t0, 6, 4, 0);
    exp_push(3, t0, 0, 1);
    exp_push(3, t0 + 2, 1, 1);
    exp_push(3, t0 + 6, 0, 0);
    exp_push(3, t0 + 6, 1, 0);
    exp_push(N, t0, 0, 1);
    exp_push(N, t0 + 10, 0, 0);
    tick(3); trig = 1'b0; tick(3);
    set_dw(2, 1, 9);
    tick(3);
    bus.i_ch_en[3] = 1'b0;
    tick(12);
    bus.i_ch_en[3] = 1'b1;
    tick(5);
    set_dw(2, 0, 0);
    set_dw(3, 0, 0);

    // async reset mid-pulse
    set_dw(0, 1, 20);
    trig_hi(k);
    t0 = k + 3;
    exp_push(0, t0, 0, 1);
    exp_push(0, t0 + 1, 1, 1);
    exp_push(0, t0 + 6, 0, 0);
    exp_push(0, t0 + 6, 1, 0);
    exp_push(N, t0, 0, 1);
    exp_push(N, t0 + 6, 0, 0);
    tick(3); trig = 1'b0; tick(6);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pulse", 64'(bus.o_pulse), 64'd0);
    chk("arst_busy", 64'(bus.o_busy), 64'd0);
    chk("arst_any", 64'(bus.o_any_busy), 64'd0);
    tick(3);
    #2 rst_n = 1'b1;
    tick(10);
    set_dw(0, 2, 2);
    trig_hi(k);
    gate(0, k + 3, 2, 2, 1);
    tick(3); trig = 1'b0; tick(12);

    mon_on = 1'b0;
    for (int c = 0; c <= N; c++) begin
      total++;
      if (exp_q[c].size() != 0) begin
        bad++;
        $display("FAIL drain q%0d left=%0d want=0", c, exp_q[c].size());
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_gate_delay_gen.md
# multi_gate_delay_gen

Multi-channel gate/delay generator: one external trigger fans out to `N_CH` independent channels, each producing a gate of programmable delay and width. Each channel has its own enable and re-trigger policy. Sits between the experiment trigger input and the downstream gate consumers (detectors, DAQ strobes), and replaces the single-channel generator where several timed gates per shot are needed. Delay/width are snapshotted per trigger, so software may rewrite them mid-sequence without corrupting a running gate.

## Interface
Parameters:
- `N_CH`, 4: number of channels (1..16).
- `CNT_W`, 32: delay/width counter width in bits.
- `MISS_W`, 16: missed-trigger counter width (used only with `GDG_MISSED_CNT_EN`).

Ports:
- `i_clk`  in  1  sole clock.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_trigger`  in  1  asynchronous trigger; rising edge starts channels.
- `i_ch_en`  in  N_CH  per-channel enable; 0 aborts/blocks channel.
- `i_retrig`  in  N_CH  per-channel mode: 1 = restart on trigger while busy, 0 = ignore.
- `i_delay`  in  N_CH*CNT_W  per-channel delay in cycles, channel c at bits [c*CNT_W +: CNT_W].
- `i_width`  in  N_CH*CNT_W  per-channel gate width in cycles, same packing.
- `i_clr_missed`  in  1  synchronous clear of all missed counters.
- `o_pulse`  out  N_CH  gate outputs, registered.
- `o_busy`  out  N_CH  channel in DELAY or PULSE, registered.
- `o_any_busy`  out  1  OR of `o_busy`.
- `o_missed`  out  N_CH*MISS_W  per-channel saturating missed-trigger counts.

## Operation
- Trigger path shared: two-FF synchroniser, then rising-edge detect into a one-cycle registered `trig_evt`.
- Per-channel FSM states: IDLE, DELAY, PULSE; down-counter `cnt` (CNT_W bits).
- Start condition: `trig_evt` && `i_ch_en[c]` && (state==IDLE || `i_retrig[c]`). On start, snapshot D=`i_delay`, W=`i_width`:
  - D>0: go to DELAY with cnt=D.
  - D==0, W>0: go to PULSE with cnt=W.
  - D==0, W==0: stay in IDLE. This is not a start and not counted as missed.
- DELAY: decrement; at cnt==1, go to PULSE with cnt=W_snap. If W_snap==0, go to IDLE instead (busy for D cycles, no gate).
- PULSE: `o_pulse` high; decrement; at cnt==1, go to IDLE.
- Missed trigger: `trig_evt` && `i_ch_en[c]` && state!=IDLE && !`i_retrig[c]`. The sequence is unaffected.
- Re-trigger in PULSE with D>0: gate drops on the next cycle, then the new delay runs.
- `i_ch_en[c]` low: channel is forced to IDLE at the next edge; `o_pulse` and `o_busy` go low. Re-enabling does not restart the channel; it waits for the next trigger.
- No arithmetic on D+W, so there is no overflow for any value up to 2^CNT_W−1.

## Timing
- Reset: all FSMs IDLE, cnt=0, sync/edge regs 0. `o_pulse`, `o_busy`, `o_any_busy` and `o_missed` are all 0.
- Latency: `i_trigger` first sampled high at edge k → `trig_evt` seen by FSMs at edge T0=k+3.
- Gate timing: `o_busy` high from after T0 for D+W cycles. `o_pulse` high from after edge T0+D for exactly W cycles.
- Minimum trigger high and low time: 2 clock cycles for guaranteed detection.
- Re-trigger accepted at T0' restarts timing relative to T0'. Back-to-back events occur at most every 2 cycles.
- `i_clr_missed` takes effect at the next edge. If an increment coincides with the clear, the clear wins.

## Configuration
- `GDG_MISSED_CNT_EN` defined: per-channel MISS_W-bit counters are implemented. They saturate at all-ones.
- Not defined: counters are not built, `o_missed` is tied to 0, and `i_clr_missed` is ignored. Port list is unchanged.

## Structure
- Package `gdg_pkg`: FSM state enum (IDLE/DELAY/PULSE), default widths, and a channel-slice helper function.
- Sub-module `gdg_channel`: one FSM, counter, snapshot registers and missed counter. Top holds the synchroniser and edge detect, and a generate loop over `N_CH`.

## Test plan
- **Basic gate:** N_CH=4; ch0 D=5, W=3; trigger at edge k → ch0 `o_pulse` high for edges k+8..k+10 exactly. `o_busy` high for 8 cycles.
- **Zero cases:**
  - D=0, W=4: pulse starts after T0, lasts 4 cycles.
  - D=0, W=0: no busy, no pulse, missed count unchanged.
  - D=3, W=0: busy 3 cycles, no pulse.
- **No-retrigger mode:** `i_retrig`=0, D=10, W=10; second trigger at T0+6 → original gate unchanged. `o_missed[ch]`=1 (with macro), 0 without.
- **Retrigger mode:** `i_retrig`=1, D=2, W=8; second trigger lands mid-pulse → pulse drops, re-rises 2 cycles after new T0, lasts 8 cycles.
- **Snapshot and enable abort:** rewrite `i_delay` during DELAY → current gate keeps the old value. Drop `i_ch_en` mid-PULSE → pulse and busy low next cycle. Other channels are unaffected.
- **Reset mid-operation:** assert `i_rst_n`=0 asynchronously mid-PULSE → all outputs 0 immediately. After release, no output activity until a new trigger edge.
